// File: rtl/conv_encoder_param_if.sv
// Handshake/bus bundle of the tail-biting convolutional encoder: block FIFO side,
// start/mode controls, output show-ahead buffer side and debug state.
interface conv_encoder_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K      = 7,
    parameter int unsigned N_OUT  = 3
);
    logic                      data_valid;
    logic [K-2:0]              tail_bits;
    logic                      code_block_length;
    logic                      blk_empty;
    logic [DATA_W-1:0]         blk_data;
    logic                      blk_data_rdreq;
    logic [N_OUT*DATA_W-1:0]   q;
    logic                      out_empty;
    logic                      rdreq_subblock;
    logic                      computation_done;
    logic                      length_out;
    logic [K-2:0]              encoder_vals;

    modport master (
        output data_valid, tail_bits, code_block_length, blk_empty, blk_data, rdreq_subblock,
        input  blk_data_rdreq, q, out_empty, computation_done, length_out, encoder_vals
    );

    modport slave (
        input  data_valid, tail_bits, code_block_length, blk_empty, blk_data, rdreq_subblock,
        output blk_data_rdreq, q, out_empty, computation_done, length_out, encoder_vals
    );
endinterface

// File: rtl/conv_encoder_param.sv
// Parametrised tail-biting convolutional encoder (rate 1/N_OUT, DATA_W bits per cycle)
// feeding a show-ahead output buffer that holds all N_OUT stream words per entry.
module conv_encoder_param #(
    parameter int unsigned           DATA_W    = 8,
    parameter int unsigned           K         = 7,
    parameter int unsigned           N_OUT     = 3,
    parameter logic [N_OUT*K-1:0]    G         = {7'o165, 7'o171, 7'o133},
    parameter int unsigned           LEN0      = 1056,
    parameter int unsigned           LEN1      = 6144,
    parameter int unsigned           OUT_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    conv_encoder_param_if.slave     bus
);
    localparam int unsigned WORDS0 = LEN0 / DATA_W;
    localparam int unsigned WORDS1 = LEN1 / DATA_W;
    localparam int unsigned CNT_W  = $clog2(WORDS1 + 1);
    localparam int unsigned PTR_W  = $clog2(OUT_DEPTH);
    localparam int unsigned BCNT_W = PTR_W + 1;
    localparam int unsigned SR_W   = K - 1;
    localparam int unsigned WIN_W  = DATA_W + SR_W;
    localparam int unsigned Q_W    = N_OUT * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state, state_next;
    logic [SR_W-1:0]     sr;
    logic                mode;
    logic [CNT_W-1:0]    req_cnt, wr_cnt, words_needed;
    logic                inflight;
    logic [Q_W-1:0]      mem [OUT_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [BCNT_W-1:0]   buf_count, occupancy;
    logic                rdreq, done, push, pop, last_word;
    logic [WIN_W-1:0]    win;
    logic [Q_W-1:0]      enc_word;
    logic [SR_W-1:0]     sr_next;
    logic                acc;

    assign words_needed = mode ? CNT_W'(WORDS1) : CNT_W'(WORDS0);
    assign occupancy    = buf_count + BCNT_W'(inflight);
    assign push         = inflight;
    assign pop          = bus.rdreq_subblock && (buf_count != '0);
    assign last_word    = push && (wr_cnt == words_needed - CNT_W'(1));

    // win[n] holds c_{n-(K-1)}: history bits from sr below, the new word (MSB first) above.
    always_comb begin
        win      = '0;
        enc_word = '0;
        sr_next  = '0;
        acc      = 1'b0;
        for (int unsigned n = 0; n < SR_W; n++)
            win[n] = sr[SR_W-1-n];
        for (int unsigned n = 0; n < DATA_W; n++)
            win[SR_W+n] = bus.blk_data[DATA_W-1-n];
        for (int unsigned j = 0; j < N_OUT; j++) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
                acc = 1'b0;
                for (int unsigned k = 0; k < K; k++)
                    acc = acc ^ (G[j*K + K-1-k] & win[i + SR_W - k]);
                enc_word[j*DATA_W + DATA_W-1-i] = acc;
            end
        end
        for (int unsigned m = 0; m < SR_W; m++)
            sr_next[m] = win[WIN_W-1-m];
    end

    always_comb begin
        state_next = state;
        rdreq      = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.data_valid)
                    state_next = S_RUN;
            end
            S_RUN: begin
                rdreq = !bus.blk_empty && (req_cnt < words_needed)
                        && (occupancy < BCNT_W'(OUT_DEPTH));
                if (last_word)
                    state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            sr        <= '0;
            mode      <= 1'b0;
            req_cnt   <= '0;
            wr_cnt    <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else begin
            state    <= state_next;
            inflight <= rdreq;
            if (state == S_IDLE && bus.data_valid) begin
                sr      <= bus.tail_bits;
                mode    <= bus.code_block_length;
                req_cnt <= '0;
                wr_cnt  <= '0;
            end else begin
                if (rdreq)
                    req_cnt <= req_cnt + CNT_W'(1);
                if (push) begin
                    sr     <= sr_next;
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            buf_count <= buf_count + BCNT_W'(push) - BCNT_W'(pop);
        end
    end

    // Storage is left unreset; the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= enc_word;
    end

    assign bus.blk_data_rdreq   = rdreq;
    assign bus.q                = (buf_count == '0) ? '0 : mem[rd_ptr];
    assign bus.out_empty        = (buf_count == '0);
    assign bus.computation_done = done;
    assign bus.length_out       = mode;
    assign bus.encoder_vals     = sr;
endmodule

// File: tb/tb_conv_encoder_param.sv
// Self-checking bench for conv_encoder_param: bit-serial golden model feeding a scoreboard,
// directed first-word table, back-pressure, random stalls and mid-block reset.
module tb_conv_encoder_param;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned K         = 7;
    localparam int unsigned N_OUT     = 3;
    localparam int unsigned Q_W       = N_OUT * DATA_W;
    localparam logic [N_OUT*K-1:0] G  = {7'o165, 7'o171, 7'o133};
    localparam int unsigned LEN0      = 1056;
    localparam int unsigned LEN1      = 6144;
    localparam int unsigned OUT_DEPTH = 16;
    localparam int unsigned W0        = LEN0 / DATA_W;
    localparam int unsigned W1        = LEN1 / DATA_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_encoder_param_if #(.DATA_W(DATA_W), .K(K), .N_OUT(N_OUT)) bus ();

    conv_encoder_param #(
        .DATA_W(DATA_W), .K(K), .N_OUT(N_OUT), .G(G),
        .LEN0(LEN0), .LEN1(LEN1), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic             mode;
        logic [7:0]       first_b;
        logic [7:0]       last_b;
        logic [Q_W-1:0]   exp_first;
    } vec_t;

    vec_t             vecs [4];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [7:0]       blk_q [$];
    logic [Q_W-1:0]   exp_q [$];
    logic             pend;
    logic             dv_now;
    int               stall_pct, pop_pct;
    int               req_seen, done_seen;
    logic [K-2:0]     ev_at_done, cur_tail;
    logic             lo_at_done, cur_mode;
    logic [Q_W-1:0]   first_q;
    logic             first_taken;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit-serial reference: r[K-2] is the most recent bit, tap vector is {c, r}.
    task automatic build_golden(input logic [K-2:0] tail_i);
        logic [K-2:0]   r;
        logic [K-1:0]   v;
        logic [Q_W-1:0] w;
        logic [7:0]     b;
        logic           c;
        for (int m = 0; m < K-1; m++) r[K-2-m] = tail_i[m];
        for (int n = 0; n < blk_q.size(); n++) begin
            b = blk_q[n];
            w = '0;
            for (int t = 0; t < DATA_W; t++) begin
                c = b[DATA_W-1-t];
                v = {c, r};
                for (int j = 0; j < N_OUT; j++)
                    w[j*DATA_W + DATA_W-1-t] = ^(v & G[j*K +: K]);
                r = {c, r[K-2:1]};
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic fill_block(input int n, input bit rnd, input logic [7:0] first_b, input logic [7:0] last_b);
        logic [7:0] b;
        blk_q.delete();
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : 8'h00;
            if (!rnd && i == 0)     b = first_b;
            if (!rnd && i == n - 1) b = last_b;
            blk_q.push_back(b);
        end
    endtask

    task automatic start_block(input logic mode_i);
        logic [7:0] lastb;
        lastb                 = blk_q[blk_q.size()-1];
        cur_tail              = lastb[K-2:0];
        cur_mode              = mode_i;
        bus.code_block_length = mode_i;
        bus.tail_bits         = cur_tail;
        exp_q.delete();
        build_golden(cur_tail);
        dv_now      = 1'b1;
        req_seen    = 0;
        done_seen   = 0;
        first_taken = 1'b0;
    endtask

    // One clock: drive at the falling edge, sample 2 time units later, well clear of the rising edge.
    task automatic cycle();
        @(negedge clk);
        bus.data_valid = dv_now;
        dv_now = 1'b0;
        if (pend) begin
            if (blk_q.size() != 0) bus.blk_data = blk_q.pop_front();
            pend = 1'b0;
        end
        bus.blk_empty      = (blk_q.size() == 0) || ($urandom_range(99) < stall_pct);
        bus.rdreq_subblock = ($urandom_range(99) < pop_pct);
        #2;
        if (bus.blk_data_rdreq) begin
            req_seen++;
            pend = 1'b1;
        end
        if (bus.computation_done) begin
            done_seen++;
            ev_at_done = bus.encoder_vals;
            lo_at_done = bus.length_out;
        end
        if (bus.out_empty) begin
            check("q_zero_when_empty", 32'(bus.q), 32'd0);
        end else if (bus.rdreq_subblock) begin
            if (!first_taken) begin
                first_q     = bus.q;
                first_taken = 1'b1;
            end
            if (exp_q.size() == 0) check("unexpected_word", 32'(bus.q), 32'hFFFF_FFFF);
            else                   check("q_word", 32'(bus.q), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic drain_and_check(input int budget, input int words);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            cycle();
            cyc++;
        end
        check("words_left_undrained", 32'(exp_q.size()), 32'd0);
        repeat (4) cycle();
        check("done_pulse_count", 32'(done_seen), 32'd1);
        check("length_out_at_done", 32'(lo_at_done), 32'(cur_mode));
        check("encoder_vals_at_done", 32'(ev_at_done), 32'(cur_tail));
        check("request_count", 32'(req_seen), 32'(words));
        check("out_empty_after", 32'(bus.out_empty), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{mode: 1'b0, first_b: 8'h00, last_b: 8'h00, exp_first: {8'h00, 8'h00, 8'h00}};
        vecs[1] = '{mode: 1'b0, first_b: 8'h80, last_b: 8'h00, exp_first: {8'hEA, 8'hF2, 8'hB6}};
        vecs[2] = '{mode: 1'b0, first_b: 8'h00, last_b: 8'h01, exp_first: {8'hD4, 8'hE4, 8'h6C}};
        vecs[3] = '{mode: 1'b0, first_b: 8'hFF, last_b: 8'h00, exp_first: {8'hB3, 8'hA3, 8'hDB}};

        reset                 = 1'b0;
        bus.data_valid        = 1'b0;
        bus.tail_bits         = '0;
        bus.code_block_length = 1'b0;
        bus.blk_empty         = 1'b1;
        bus.blk_data          = '0;
        bus.rdreq_subblock    = 1'b0;
        pend = 1'b0; dv_now = 1'b0; stall_pct = 0; pop_pct = 0;
        ev_at_done = '0; lo_at_done = 1'b0; first_q = '0; first_taken = 1'b0;
        cur_tail = '0; cur_mode = 1'b0; req_seen = 0; done_seen = 0;

        repeat (2) @(negedge clk);
        #2;
        check("reset_rdreq", 32'(bus.blk_data_rdreq), 32'd0);
        check("reset_done", 32'(bus.computation_done), 32'd0);
        check("reset_length_out", 32'(bus.length_out), 32'd0);
        check("reset_encoder_vals", 32'(bus.encoder_vals), 32'd0);
        check("reset_q", 32'(bus.q), 32'd0);
        check("reset_out_empty", 32'(bus.out_empty), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 4; v++) begin
            stall_pct = 0;
            pop_pct   = 100;
            fill_block(W0, 1'b0, vecs[v].first_b, vecs[v].last_b);
            start_block(vecs[v].mode);
            drain_and_check(1000, W0);
            check("first_word", 32'(first_q), 32'(vecs[v].exp_first));
        end

        // Back-pressure: no pops, requests must stop once the buffer is full.
        stall_pct = 0;
        pop_pct   = 0;
        fill_block(W1, 1'b1, 8'h00, 8'h00);
        start_block(1'b1);
        repeat (60) cycle();
        check("backpressure_requests", 32'(req_seen), 32'(OUT_DEPTH));
        check("backpressure_not_empty", 32'(bus.out_empty), 32'd0);
        pop_pct = 100;
        drain_and_check(3000, W1);

        // Random FIFO stalls and random pops, including pops while empty.
        stall_pct = 40;
        pop_pct   = 50;
        fill_block(W1, 1'b1, 8'h00, 8'h00);
        start_block(1'b1);
        drain_and_check(20000, W1);

        // Reset in the middle of a block, then a fresh mode-0 block.
        stall_pct = 0;
        pop_pct   = 100;
        fill_block(W1, 1'b1, 8'h00, 8'h00);
        start_block(1'b1);
        begin
            int cyc;
            cyc = 0;
            while (req_seen < 50 && cyc < 400) begin
                cycle();
                cyc++;
            end
        end
        check("midblock_reached_50", 32'(req_seen >= 50), 32'd1);
        reset = 1'b0;
        #1;
        check("midreset_out_empty", 32'(bus.out_empty), 32'd1);
        check("midreset_rdreq", 32'(bus.blk_data_rdreq), 32'd0);
        check("midreset_q", 32'(bus.q), 32'd0);
        check("midreset_encoder_vals", 32'(bus.encoder_vals), 32'd0);
        check("midreset_length_out", 32'(bus.length_out), 32'd0);
        blk_q.delete();
        exp_q.delete();
        pend   = 1'b0;
        dv_now = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        stall_pct = 20;
        pop_pct   = 70;
        fill_block(W0, 1'b1, 8'h00, 8'h00);
        start_block(1'b0);
        drain_and_check(5000, W0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
